// File: rtl/amba3_axi_wr_arbiter_pkg.sv
// Shared AMBA3 AXI types for the write/read-path arbiters: burst and response
// encodings, the AW control payload, and the round-robin pointer helper.
package pkg_amba3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef struct packed {
        logic [3:0] len;
        logic [2:0] size;
        burst_t     burst;
    } aw_ctrl_t;

    // Index following idx, wrapping at n (n need not be a power of two).
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/amba3_axi_idx_fifo.sv
// Small synchronous FIFO of master indices; records grant order so the data
// channel follows the address channel.
module amba3_axi_idx_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    // Push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push_s = push & (~full | pop);
    assign do_pop_s  = pop & ~empty;

    assign full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign dout  = mem_r[rd_ptr_r[PW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[PW-1:0]] <= din;
                wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/amba3_axi_wr_arbiter.sv
// N:1 AXI3 write arbiter: round-robin AW with index-tagged AWID, W steered in
// grant order through an index FIFO, B returned by the AWID index prefix.
module amba3_axi_wr_arbiter
    import pkg_amba3::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TXID_SIZE   = 4,
    parameter int ADDR_SIZE   = 32,
    parameter int DATA_SIZE   = 128,
    parameter int FIFO_DEPTH  = 4,
    parameter int MIDX_SIZE   = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                             aclk,
    input  logic                             areset_n,
    input  logic [NUM_MASTERS-1:0]           s_awvalid,
    output logic [NUM_MASTERS-1:0]           s_awready,
    input  logic [NUM_MASTERS*TXID_SIZE-1:0] s_awid,
    input  logic [NUM_MASTERS*ADDR_SIZE-1:0] s_awaddr,
    input  logic [NUM_MASTERS*4-1:0]         s_awlen,
    input  logic [NUM_MASTERS*3-1:0]         s_awsize,
    input  logic [NUM_MASTERS*2-1:0]         s_awburst,
    input  logic [NUM_MASTERS-1:0]           s_wvalid,
    output logic [NUM_MASTERS-1:0]           s_wready,
    input  logic [NUM_MASTERS*DATA_SIZE-1:0] s_wdata,
    input  logic [NUM_MASTERS*DATA_SIZE/8-1:0] s_wstrb,
    input  logic [NUM_MASTERS-1:0]           s_wlast,
    output logic [NUM_MASTERS-1:0]           s_bvalid,
    input  logic [NUM_MASTERS-1:0]           s_bready,
    output logic [TXID_SIZE-1:0]             s_bid,
    output logic [1:0]                       s_bresp,
    output logic                             m_awvalid,
    input  logic                             m_awready,
    output logic [TXID_SIZE+MIDX_SIZE-1:0]   m_awid,
    output logic [ADDR_SIZE-1:0]             m_awaddr,
    output logic [3:0]                       m_awlen,
    output logic [2:0]                       m_awsize,
    output logic [1:0]                       m_awburst,
    output logic                             m_wvalid,
    input  logic                             m_wready,
    output logic [DATA_SIZE-1:0]             m_wdata,
    output logic [DATA_SIZE/8-1:0]           m_wstrb,
    output logic                             m_wlast,
    input  logic                             m_bvalid,
    output logic                             m_bready,
    input  logic [TXID_SIZE+MIDX_SIZE-1:0]   m_bid,
    input  logic [1:0]                       m_bresp,
    output logic                             err_bid
);

    localparam int IDW  = TXID_SIZE + MIDX_SIZE;
    localparam int STRB = DATA_SIZE / 8;

    logic [TXID_SIZE-1:0] awid_a  [NUM_MASTERS];
    logic [ADDR_SIZE-1:0] awaddr_a[NUM_MASTERS];
    aw_ctrl_t             ctrl_a  [NUM_MASTERS];
    logic [DATA_SIZE-1:0] wdata_a [NUM_MASTERS];
    logic [STRB-1:0]      wstrb_a [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign awid_a[i]   = s_awid[i*TXID_SIZE +: TXID_SIZE];
        assign awaddr_a[i] = s_awaddr[i*ADDR_SIZE +: ADDR_SIZE];
        assign ctrl_a[i]   = {s_awlen[i*4 +: 4], s_awsize[i*3 +: 3], s_awburst[i*2 +: 2]};
        assign wdata_a[i]  = s_wdata[i*DATA_SIZE +: DATA_SIZE];
        assign wstrb_a[i]  = s_wstrb[i*STRB +: STRB];
    end

    logic                 run_r;
    logic [MIDX_SIZE-1:0] rr_ptr_r;
    logic                 m_awvalid_r;
    logic [MIDX_SIZE-1:0] aw_idx_r;
    logic [TXID_SIZE-1:0] aw_id_r;
    logic [ADDR_SIZE-1:0] aw_addr_r;
    aw_ctrl_t             aw_ctrl_r;
    logic                 err_bid_r;

    logic                 hi_found_s, lo_found_s, found_s;
    logic [MIDX_SIZE-1:0] hi_idx_s, lo_idx_s, winner_s;
    logic                 slot_free_s, aw_accept_s;
    logic                 fifo_full_s, fifo_empty_s, w_pop_s;
    logic [MIDX_SIZE-1:0] head_s;
    logic [MIDX_SIZE-1:0] bidx_s;
    logic                 bidx_bad_s;

    // Outputs stay quiet until the first clock after reset release.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Round-robin pick: lowest requester at/above the pointer, else lowest overall.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (s_awvalid[i] && (i >= int'(rr_ptr_r))) begin
                hi_found_s = 1'b1;
                hi_idx_s   = MIDX_SIZE'(i);
            end else if (s_awvalid[i]) begin
                lo_found_s = 1'b1;
                lo_idx_s   = MIDX_SIZE'(i);
            end else begin
                lo_found_s = lo_found_s;
            end
        end
    end

    assign found_s     = hi_found_s | lo_found_s;
    assign winner_s    = hi_found_s ? hi_idx_s : lo_idx_s;
    assign slot_free_s = ~m_awvalid_r | m_awready;
    assign aw_accept_s = run_r & found_s & slot_free_s & ~fifo_full_s;

    // Only the winner sees ready.
    always_comb begin
        s_awready           = '0;
        s_awready[winner_s] = aw_accept_s;
    end

    // One-entry AW output register and pointer advance.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            m_awvalid_r <= 1'b0;
            aw_idx_r    <= '0;
            aw_id_r     <= '0;
            aw_addr_r   <= '0;
            aw_ctrl_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (aw_accept_s) begin
            m_awvalid_r <= 1'b1;
            aw_idx_r    <= winner_s;
            aw_id_r     <= awid_a[winner_s];
            aw_addr_r   <= awaddr_a[winner_s];
            aw_ctrl_r   <= ctrl_a[winner_s];
            rr_ptr_r    <= MIDX_SIZE'(rr_next(int'(winner_s), NUM_MASTERS));
        end else if (m_awready) begin
            m_awvalid_r <= 1'b0;
        end else begin
            m_awvalid_r <= m_awvalid_r;
        end
    end

    assign m_awvalid = m_awvalid_r;
    assign m_awid    = {aw_idx_r, aw_id_r};
    assign m_awaddr  = aw_addr_r;
    assign m_awlen   = aw_ctrl_r.len;
    assign m_awsize  = aw_ctrl_r.size;
    assign m_awburst = aw_ctrl_r.burst;

    amba3_axi_idx_fifo #(
        .WIDTH (MIDX_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_idx_fifo (
        .clk   (aclk),
        .rst_n (areset_n),
        .push  (aw_accept_s),
        .din   (winner_s),
        .pop   (w_pop_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // W is steered from the oldest granted master only.
    always_comb begin
        s_wready = '0;
        m_wdata  = wdata_a[head_s];
        m_wstrb  = wstrb_a[head_s];
        m_wlast  = s_wlast[head_s];
        if (run_r && !fifo_empty_s) begin
            m_wvalid         = s_wvalid[head_s];
            s_wready[head_s] = m_wready;
        end else begin
            m_wvalid = 1'b0;
        end
    end

    assign w_pop_s = m_wvalid & m_wready & m_wlast;

    assign bidx_s     = m_bid[IDW-1 -: MIDX_SIZE];
    assign bidx_bad_s = (int'(bidx_s) >= NUM_MASTERS);
    assign s_bid      = m_bid[TXID_SIZE-1:0];
    assign s_bresp    = m_bresp;

    // B return path; unknown indices are sunk so the slave never stalls.
    always_comb begin
        s_bvalid = '0;
        m_bready = 1'b0;
        if (!run_r) begin
            m_bready = 1'b0;
        end else if (bidx_bad_s) begin
            m_bready = 1'b1;
        end else begin
            s_bvalid[bidx_s] = m_bvalid;
            m_bready         = s_bready[bidx_s];
        end
    end

    // One pulse per dropped B beat.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            err_bid_r <= 1'b0;
        end else begin
            err_bid_r <= run_r & m_bvalid & bidx_bad_s;
        end
    end

    assign err_bid = err_bid_r;

endmodule

// File: tb/tb_amba3_axi_wr_arbiter.sv
// Randomized bench for amba3_axi_wr_arbiter with a queue-based reference model
// of grant order, W ordering and B routing.
module tb_amba3_axi_wr_arbiter;

    localparam int N   = 3;
    localparam int TX  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int FD  = 4;
    localparam int MX  = 2;
    localparam int IDW = TX + MX;
    localparam int PLW = IDW + AW + 9;

    logic              aclk;
    logic              areset_n;
    logic [N-1:0]      s_awvalid, s_awready;
    logic [N*TX-1:0]   s_awid;
    logic [N*AW-1:0]   s_awaddr;
    logic [N*4-1:0]    s_awlen;
    logic [N*3-1:0]    s_awsize;
    logic [N*2-1:0]    s_awburst;
    logic [N-1:0]      s_wvalid, s_wready;
    logic [N*DW-1:0]   s_wdata;
    logic [N*SW-1:0]   s_wstrb;
    logic [N-1:0]      s_wlast;
    logic [N-1:0]      s_bvalid, s_bready;
    logic [TX-1:0]     s_bid;
    logic [1:0]        s_bresp;
    logic              m_awvalid, m_awready;
    logic [IDW-1:0]    m_awid;
    logic [AW-1:0]     m_awaddr;
    logic [3:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_wvalid, m_wready;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_wlast;
    logic              m_bvalid, m_bready;
    logic [IDW-1:0]    m_bid;
    logic [1:0]        m_bresp;
    logic              err_bid;

    amba3_axi_wr_arbiter #(
        .NUM_MASTERS (N),
        .TXID_SIZE   (TX),
        .ADDR_SIZE   (AW),
        .DATA_SIZE   (DW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .aclk      (aclk),      .areset_n  (areset_n),
        .s_awvalid (s_awvalid), .s_awready (s_awready),
        .s_awid    (s_awid),    .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),   .s_awsize  (s_awsize),  .s_awburst (s_awburst),
        .s_wvalid  (s_wvalid),  .s_wready  (s_wready),
        .s_wdata   (s_wdata),   .s_wstrb   (s_wstrb),   .s_wlast   (s_wlast),
        .s_bvalid  (s_bvalid),  .s_bready  (s_bready),
        .s_bid     (s_bid),     .s_bresp   (s_bresp),
        .m_awvalid (m_awvalid), .m_awready (m_awready),
        .m_awid    (m_awid),    .m_awaddr  (m_awaddr),
        .m_awlen   (m_awlen),   .m_awsize  (m_awsize),  .m_awburst (m_awburst),
        .m_wvalid  (m_wvalid),  .m_wready  (m_wready),
        .m_wdata   (m_wdata),   .m_wstrb   (m_wstrb),   .m_wlast   (m_wlast),
        .m_bvalid  (m_bvalid),  .m_bready  (m_bready),
        .m_bid     (m_bid),     .m_bresp   (m_bresp),
        .err_bid   (err_bid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: grant pointer, AW output slot, grant-order queue.
    int             ptr;
    bit             slot_v;
    logic [PLW-1:0] slot_pl;
    int             order[$];
    bit             err_exp;

    // Upstream master and downstream slave stimulus state.
    bit             aw_on[N];
    logic [TX-1:0]  mst_id[N];
    logic [AW-1:0]  mst_addr[N];
    logic [3:0]     mst_len[N];
    logic [2:0]     mst_size[N];
    logic [1:0]     mst_burst[N];
    logic [DW:0]    wq[N][$];
    bit             w_on[N];
    bit             b_on;
    logic [IDW-1:0] b_id;
    logic [1:0]     b_resp;

    task automatic clear_all();
        ptr = 0; slot_v = 1'b0; slot_pl = '0; order.delete(); err_exp = 1'b0;
        b_on = 1'b0; b_id = '0; b_resp = 2'd0;
        for (int m = 0; m < N; m++) begin
            aw_on[m] = 1'b0; w_on[m] = 1'b0; wq[m].delete();
        end
        s_awvalid = '0; s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; m_bresp = 2'd0;
    endtask

    task automatic drive_inputs(input int wr_pct);
        for (int m = 0; m < N; m++) begin
            if (!aw_on[m] && $urandom_range(0, 99) < 45) begin
                aw_on[m]     = 1'b1;
                mst_id[m]    = TX'($urandom);
                mst_addr[m]  = AW'($urandom);
                mst_len[m]   = 4'($urandom_range(0, 3));
                mst_size[m]  = 3'd2;
                mst_burst[m] = 2'($urandom_range(0, 2));
                for (int b = 0; b <= int'(mst_len[m]); b++) begin
                    wq[m].push_back({(b == int'(mst_len[m])), DW'($urandom)});
                end
            end
            if (!w_on[m] && wq[m].size() > 0 && $urandom_range(0, 99) < 60) w_on[m] = 1'b1;
            s_awvalid[m]           = aw_on[m];
            s_awid[m*TX +: TX]     = mst_id[m];
            s_awaddr[m*AW +: AW]   = mst_addr[m];
            s_awlen[m*4 +: 4]      = mst_len[m];
            s_awsize[m*3 +: 3]     = mst_size[m];
            s_awburst[m*2 +: 2]    = mst_burst[m];
            s_wvalid[m]            = w_on[m];
            s_wstrb[m*SW +: SW]    = SW'(m + 1);
            s_wdata[m*DW +: DW]    = w_on[m] ? wq[m][0][DW-1:0] : DW'($urandom);
            s_wlast[m]             = w_on[m] ? wq[m][0][DW] : 1'b0;
        end
        s_bready  = N'($urandom);
        m_awready = ($urandom_range(0, 99) < 50);
        m_wready  = ($urandom_range(0, 99) < wr_pct);
        if (!b_on && $urandom_range(0, 99) < 30) begin
            b_on   = 1'b1;
            b_id   = {MX'($urandom_range(0, 3)), TX'($urandom)};
            b_resp = 2'($urandom);
        end
        m_bvalid = b_on;
        m_bid    = b_id;
        m_bresp  = b_resp;
    endtask

    task automatic check_and_step();
        bit           free, full, exp_wv;
        int           g, h, bidx;
        logic [N-1:0] exp_awr, exp_wr, exp_bv;
        logic         exp_br;
        free = !slot_v || m_awready;
        full = (order.size() >= FD);
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && s_awvalid[(ptr + k) % N]) g = (ptr + k) % N;
        end
        exp_awr = '0;
        if (g >= 0 && free && !full) exp_awr[g] = 1'b1;
        check("s_awready", s_awready, exp_awr);
        check("m_awvalid", m_awvalid, slot_v);
        if (slot_v) check("m_aw_payload", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst}, slot_pl);

        exp_wv = 1'b0; exp_wr = '0; h = 0;
        if (order.size() > 0) begin
            h = order[0];
            exp_wv = s_wvalid[h];
            exp_wr[h] = m_wready;
        end
        check("s_wready", s_wready, exp_wr);
        check("m_wvalid", m_wvalid, exp_wv);
        if (exp_wv) check("m_w_beat", {m_wlast, m_wstrb, m_wdata}, {wq[h][0][DW], SW'(h + 1), wq[h][0][DW-1:0]});

        bidx = int'(b_id[IDW-1 -: MX]);
        exp_bv = '0;
        exp_br = 1'b1;
        if (bidx < N) begin
            exp_bv[bidx] = m_bvalid;
            exp_br = s_bready[bidx];
        end
        check("s_bvalid", s_bvalid, exp_bv);
        check("m_bready", m_bready, exp_br);
        if (m_bvalid && bidx < N) check("s_b_payload", {s_bid, s_bresp}, {b_id[TX-1:0], b_resp});
        check("err_bid", err_bid, err_exp);
        err_exp = m_bvalid && (bidx >= N);

        if (exp_wv && m_wready) begin
            if (wq[h][0][DW]) void'(order.pop_front());
            void'(wq[h].pop_front());
            w_on[h] = 1'b0;
        end
        if (exp_awr != '0) begin
            order.push_back(g);
            slot_v  = 1'b1;
            slot_pl = {MX'(g), mst_id[g], mst_addr[g], mst_len[g], mst_size[g], mst_burst[g]};
            ptr     = (g + 1) % N;
            aw_on[g] = 1'b0;
        end else if (m_awready) begin
            slot_v = 1'b0;
        end
        if (m_bvalid && exp_br) b_on = 1'b0;
    endtask

    task automatic run_cycles(input int cycles, input int wr_pct);
        for (int c = 0; c < cycles; c++) begin
            @(posedge aclk);
            #1;
            drive_inputs(wr_pct);
            @(negedge aclk);
            check_and_step();
        end
    endtask

    task automatic release_reset();
        @(posedge aclk);
        #1;
        clear_all();
        areset_n = 1'b1;
    endtask

    initial begin
        areset_n = 1'b0;
        clear_all();
        s_awvalid = '1;
        m_bvalid  = 1'b1;
        m_wready  = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_ctrl", {m_awvalid, s_awready, s_wready, m_wvalid, s_bvalid, m_bready, err_bid}, '0);
        check("rst_payload", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst}, '0);
        release_reset();

        run_cycles(60, 0);
        run_cycles(500, 25);
        run_cycles(400, 85);

        @(posedge aclk);
        #1;
        areset_n = 1'b0;
        #1;
        check("midrst_ctrl", {m_awvalid, s_awready, s_wready, m_wvalid, s_bvalid, m_bready, err_bid}, '0);
        clear_all();
        repeat (2) @(posedge aclk);
        release_reset();

        run_cycles(400, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
